// File: rtl/arb_pkg.sv
// Shared types and default widths for the round-robin line-memory arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } arb_state_t;

    typedef enum logic {
        ARB_READ,
        ARB_WRITE
    } arb_op_t;

    localparam int ARB_LINE_WIDTH = 256;
    localparam int ARB_ADDR_WIDTH = 32;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester after ptr_i, scanning upwards modulo NUM_REQ.
module rr_picker #(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic               valid_o,
    output logic [IDX_W-1:0]   grant_o
);

    int unsigned idx;

    // Scan from the farthest offset down so the nearest requester after ptr_i wins.
    always_comb begin
        valid_o = |req_i;
        grant_o = '0;
        idx     = 0;
        for (int unsigned k = NUM_REQ; k > 0; k--) begin
            idx = (ptr_i + k) % NUM_REQ;
            if (req_i[idx]) begin
                grant_o = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter_rr.sv
// N-requester round-robin line-memory arbiter, one outstanding transaction, guard cycle after each response.
// Optional per-channel performance counters when ARB_PERF_CNT_EN is defined.
module mem_arbiter_rr
    import arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int LINE_WIDTH = ARB_LINE_WIDTH,
    parameter int ADDR_WIDTH = ARB_ADDR_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_read,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*LINE_WIDTH-1:0] req_wdata,
    output logic [LINE_WIDTH-1:0]         req_rdata,
    output logic [NUM_REQ-1:0]            req_resp,
    output logic                          mem_read,
    output logic                          mem_write,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [LINE_WIDTH-1:0]         mem_wdata,
    input  logic [LINE_WIDTH-1:0]         mem_rdata,
    input  logic                          mem_resp
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [NUM_REQ*32-1:0]         perf_grant_cnt,
    output logic [NUM_REQ*32-1:0]         perf_wait_cnt
`endif
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t            state_q, state_d;
    arb_op_t               op_q;
    logic                  act_q;
    logic [IDX_W-1:0]      grant_q;
    logic [IDX_W-1:0]      rr_ptr_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LINE_WIDTH-1:0] wdata_q;

    logic [NUM_REQ-1:0]    req_vec;
    logic                  pick_valid;
    logic [IDX_W-1:0]      pick_idx;
    logic                  take;
    logic                  complete;

    assign req_vec = req_read | req_write;

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req_i   (req_vec),
        .ptr_i   (rr_ptr_q),
        .valid_o (pick_valid),
        .grant_o (pick_idx)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        take      = 1'b0;
        complete  = 1'b0;
        req_resp  = '0;
        req_rdata = '0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    take    = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (mem_resp) begin
                    complete           = 1'b1;
                    req_resp[grant_q]  = 1'b1;
                    req_rdata          = mem_rdata;
                    state_d            = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A channel asserting both read and write is issued as a write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q     <= ARB_READ;
            act_q    <= 1'b0;
            grant_q  <= '0;
            rr_ptr_q <= IDX_W'(NUM_REQ - 1);
            addr_q   <= '0;
            wdata_q  <= '0;
        end else if (take) begin
            op_q     <= req_write[pick_idx] ? ARB_WRITE : ARB_READ;
            act_q    <= 1'b1;
            grant_q  <= pick_idx;
            rr_ptr_q <= pick_idx;
            addr_q   <= req_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_q  <= req_wdata[pick_idx*LINE_WIDTH +: LINE_WIDTH];
        end else if (complete) begin
            act_q    <= 1'b0;
        end
    end

    assign mem_read  = act_q && (op_q == ARB_READ);
    assign mem_write = act_q && (op_q == ARB_WRITE);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

`ifdef ARB_PERF_CNT_EN
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_perf
        logic [31:0] grant_cnt_q;
        logic [31:0] wait_cnt_q;
        logic        granted_now;
        logic        in_svc;

        // The channel being granted this cycle, or held in BUSY/DONE, is not waiting.
        assign granted_now = take && (pick_idx == IDX_W'(g));
        assign in_svc      = granted_now || ((state_q != IDLE) && (grant_q == IDX_W'(g)));

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                grant_cnt_q <= '0;
                wait_cnt_q  <= '0;
            end else begin
                if (granted_now && (grant_cnt_q != '1)) begin
                    grant_cnt_q <= grant_cnt_q + 32'd1;
                end
                if (req_vec[g] && !in_svc && (wait_cnt_q != '1)) begin
                    wait_cnt_q <= wait_cnt_q + 32'd1;
                end
            end
        end

        assign perf_grant_cnt[g*32 +: 32] = grant_cnt_q;
        assign perf_wait_cnt[g*32 +: 32]  = wait_cnt_q;
    end
`endif

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Self-checking bench for mem_arbiter_rr (NUM_REQ=4): directed table, corner sequences, random vs. model.
module tb_mem_arbiter_rr;

    localparam int NR = 4;
    localparam int LW = 256;
    localparam int AW = 32;

    logic             clk;
    logic             reset_n;
    logic [NR-1:0]    req_read;
    logic [NR-1:0]    req_write;
    logic [NR*AW-1:0] req_addr;
    logic [NR*LW-1:0] req_wdata;
    logic [LW-1:0]    req_rdata;
    logic [NR-1:0]    req_resp;
    logic             mem_read;
    logic             mem_write;
    logic [AW-1:0]    mem_addr;
    logic [LW-1:0]    mem_wdata;
    logic [LW-1:0]    mem_rdata;
    logic             mem_resp;

    int n_cmp  = 0;
    int n_fail = 0;

    mem_arbiter_rr #(
        .NUM_REQ    (NR),
        .LINE_WIDTH (LW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_read  (req_read),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_rdata (req_rdata),
        .req_resp  (req_resp),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_resp  (mem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [NR-1:0] rd;
        logic [NR-1:0] wr;
        int            dly;
        int            gnt;
        logic          wr_exp;
        logic [LW-1:0] rdata;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] ch_addr(input int c);
        return 32'h0000_1000 + 32'(c) * 32'h100;
    endfunction

    function automatic logic [LW-1:0] ch_line(input int c);
        return {8{32'hC0DE_0000 | 32'(c)}};
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] l;
        for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic clear_reqs();
        req_read  = '0;
        req_write = '0;
    endtask

    task automatic load_fixed();
        for (int c = 0; c < NR; c++) begin
            req_addr[c*AW +: AW]  = ch_addr(c);
            req_wdata[c*LW +: LW] = ch_line(c);
        end
    endtask

    task automatic wait_op(output int k);
        k = 0;
        do begin
            cyc();
            mem_resp = 1'b0;
            #4;
            k++;
        end while (!(mem_read || mem_write) && k < 12);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_reqs();
        mem_resp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // Random-phase model state
    int            m_phase, m_gnt, m_last, m_wait;
    logic          m_wr;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_wdata;
    logic [NR-1:0] pend, p_rd, p_wr, served;

    initial begin
        int k;
        tbl[0] = '{rd: 4'b0001, wr: 4'b0000, dly: 0, gnt: 0, wr_exp: 1'b0, rdata: {32{8'hA5}}};
        tbl[1] = '{rd: 4'b0001, wr: 4'b0010, dly: 2, gnt: 1, wr_exp: 1'b1, rdata: {32{8'h3C}}};
        tbl[2] = '{rd: 4'b0001, wr: 4'b0010, dly: 1, gnt: 0, wr_exp: 1'b0, rdata: {32{8'h5A}}};
        tbl[3] = '{rd: 4'b1000, wr: 4'b0000, dly: 0, gnt: 3, wr_exp: 1'b0, rdata: {16{16'hBEEF}}};
        tbl[4] = '{rd: 4'b0101, wr: 4'b0000, dly: 3, gnt: 0, wr_exp: 1'b0, rdata: {8{32'h1234_5678}}};
        tbl[5] = '{rd: 4'b0100, wr: 4'b0100, dly: 1, gnt: 2, wr_exp: 1'b1, rdata: {8{32'hDEAD_0005}}};
        tbl[6] = '{rd: 4'b1111, wr: 4'b0000, dly: 0, gnt: 3, wr_exp: 1'b0, rdata: {8{32'hFACE_0006}}};
        tbl[7] = '{rd: 4'b1111, wr: 4'b0000, dly: 2, gnt: 0, wr_exp: 1'b0, rdata: {8{32'hCAFE_0007}}};

        clear_reqs();
        load_fixed();
        mem_resp  = 1'b1;
        mem_rdata = {32{8'hFF}};
        reset_n   = 1'b0;
        #3;
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_req_resp", req_resp, 0);
        chk("rst_req_rdata", req_rdata, 0);
        mem_resp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Directed table: rr pointer carries across rows
        for (int i = 0; i < 8; i++) begin
            cyc();
            req_read  = tbl[i].rd;
            req_write = tbl[i].wr;
            #4;
            chk("tbl_idle_resp", req_resp, 0);
            wait_op(k);
            chk("tbl_latency", k, 1);
            chk("tbl_mem_read", mem_read, !tbl[i].wr_exp);
            chk("tbl_mem_write", mem_write, tbl[i].wr_exp);
            chk("tbl_mem_addr", mem_addr, ch_addr(tbl[i].gnt));
            chk("tbl_mem_wdata", mem_wdata, ch_line(tbl[i].gnt));
            for (int d = 0; d < tbl[i].dly; d++) begin
                cyc();
                #4;
                chk("tbl_hold", {mem_read, mem_write}, {!tbl[i].wr_exp, tbl[i].wr_exp});
            end
            cyc();
            mem_resp  = 1'b1;
            mem_rdata = tbl[i].rdata;
            #4;
            chk("tbl_req_resp", req_resp, 4'b0001 << tbl[i].gnt);
            chk("tbl_req_rdata", req_rdata, tbl[i].rdata);
            cyc();
            mem_resp = 1'b0;
            clear_reqs();
            #4;
            chk("tbl_deassert", {mem_read, mem_write}, 2'b00);
            chk("tbl_guard_resp", req_resp, 0);
            cyc();
        end

        // Request dropped while in service still completes
        cyc();
        req_read = 4'b0010;
        wait_op(k);
        chk("drop_latency", k, 1);
        chk("drop_addr", mem_addr, ch_addr(1));
        cyc();
        req_read = '0;
        #4;
        chk("drop_hold_t2", mem_read, 1);
        cyc();
        #4;
        chk("drop_hold_t3", mem_read, 1);
        cyc();
        mem_resp  = 1'b1;
        mem_rdata = {8{32'h0D0D_0D0D}};
        #4;
        chk("drop_req_resp", req_resp, 4'b0010);
        cyc();
        mem_resp = 1'b0;
        #4;
        chk("drop_deassert", mem_read, 0);
        cyc();

        // Reset asserted mid-transaction
        cyc();
        req_read = 4'b0100;
        wait_op(k);
        chk("rstmid_addr", mem_addr, ch_addr(2));
        cyc();
        mem_resp = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        chk("rstmid_mem_read", mem_read, 0);
        chk("rstmid_req_resp", req_resp, 0);
        clear_reqs();
        mem_resp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n  = 1'b1;
        mem_resp = 1'b1;
        #4;
        chk("rstmid_stray_resp", req_resp, 0);
        cyc();
        mem_resp = 1'b0;
        req_read = 4'b0101;
        wait_op(k);
        chk("rstmid_ch0_wins", mem_addr, ch_addr(0));
        cyc();
        mem_resp = 1'b1;
        #4;
        chk("rstmid_resp", req_resp, 4'b0001);
        cyc();
        mem_resp = 1'b0;
        clear_reqs();
        cyc();

        // Fairness: all channels request continuously from reset
        do_reset();
        req_read = '1;
        for (int t = 0; t < 6; t++) begin
            wait_op(k);
            chk("fair_latency", k, (t == 0) ? 1 : 3);
            chk("fair_order", mem_addr, ch_addr(t % NR));
            repeat (2) begin
                cyc();
                #4;
            end
            cyc();
            mem_resp = 1'b1;
            #4;
            chk("fair_resp", req_resp, 4'b0001 << (t % NR));
        end
        cyc();
        mem_resp = 1'b0;
        clear_reqs();
        cyc();

        // Randomized traffic against the reference model
        do_reset();
        m_phase = 0;
        m_last  = NR - 1;
        m_gnt   = 0;
        m_wait  = 0;
        m_wr    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        pend    = '0;
        p_rd    = '0;
        p_wr    = '0;
        served  = '0;
        for (int n = 0; n < 2000; n++) begin
            logic e_busy, e_resp;
            cyc();
            mem_resp = 1'b0;
            for (int c = 0; c < NR; c++) begin
                if (pend[c] && served[c]) begin
                    pend[c] = 1'b0;
                end else if (!pend[c]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        int kind;
                        kind    = int'($urandom_range(0, 2));
                        pend[c] = 1'b1;
                        p_rd[c] = (kind != 1);
                        p_wr[c] = (kind != 0);
                        req_addr[c*AW +: AW]  = $urandom;
                        req_wdata[c*LW +: LW] = rand_line();
                    end
                end else if ($urandom_range(0, 63) == 0) begin
                    pend[c] = 1'b0;
                end
            end
            req_read  = pend & p_rd;
            req_write = pend & p_wr;
            mem_rdata = rand_line();
            if (m_phase == 1) begin
                if (m_wait == 0) mem_resp = 1'b1;
                else m_wait--;
            end else begin
                mem_resp = ($urandom_range(0, 15) == 0);
            end
            #4;
            e_busy = (m_phase == 1);
            e_resp = e_busy && mem_resp;
            chk("rnd_mem_read", mem_read, e_busy && !m_wr);
            chk("rnd_mem_write", mem_write, e_busy && m_wr);
            chk("rnd_req_resp", req_resp, e_resp ? (4'b0001 << m_gnt) : 4'b0000);
            chk("rnd_req_rdata", req_rdata, e_resp ? mem_rdata : '0);
            if (e_busy) begin
                chk("rnd_mem_addr", mem_addr, m_addr);
                chk("rnd_mem_wdata", mem_wdata, m_wdata);
            end
            served = e_resp ? (4'b0001 << m_gnt) : 4'b0000;

            if (m_phase == 0) begin
                logic [NR-1:0] p;
                p = req_read | req_write;
                if (p != 0) begin
                    for (int s = NR; s >= 1; s--) begin
                        if (p[(m_last + s) % NR]) m_gnt = (m_last + s) % NR;
                    end
                    m_last  = m_gnt;
                    m_wr    = req_write[m_gnt];
                    m_addr  = req_addr[m_gnt*AW +: AW];
                    m_wdata = req_wdata[m_gnt*LW +: LW];
                    m_wait  = int'($urandom_range(0, 3));
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (mem_resp) m_phase = 2;
            end else begin
                m_phase = 0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter_rr.md
Name: mem_arbiter_rr

Overview:
- Parametrised N-requester line-memory arbiter; successor to the two-port I/D arbiter.
- Sits between NUM_REQ L1 caches (I, D, prefetcher, etc.) and a single L2 or cacheline_adapter port.
- Round-robin fair grant, latched transaction, one outstanding request at a time.
- Adds fairness, deterministic request latching and a post-response guard cycle, none of which the two-port arbiter has.

Parameters:
NUM_REQ, 2, number of requesting channels (2..8)
LINE_WIDTH, 256, cacheline data width in bits
ADDR_WIDTH, 32, address width in bits

Ports:
clk  input  1  clock, rising-edge
reset_n  input  1  asynchronous active-low reset
req_read  input  NUM_REQ  per-channel line read request, level, held until req_resp
req_write  input  NUM_REQ  per-channel line write request, level, held until req_resp
req_addr  input  NUM_REQ*ADDR_WIDTH  per-channel line address; channel i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  input  NUM_REQ*LINE_WIDTH  per-channel write line; same slicing rule as req_addr
req_rdata  output  LINE_WIDTH  read line, broadcast to all channels
req_resp  output  NUM_REQ  one-hot completion pulse to the granted channel
mem_read  output  1  downstream read
mem_write  output  1  downstream write
mem_addr  output  ADDR_WIDTH  downstream address
mem_wdata  output  LINE_WIDTH  downstream write line
mem_rdata  input  LINE_WIDTH  downstream read line
mem_resp  input  1  downstream completion, one-cycle pulse

Behaviour:
- Reset is asynchronous on negedge reset_n. All of the following hold immediately:
  - state = IDLE.
  - mem_read, mem_write, mem_addr, mem_wdata, req_resp, req_rdata = 0.
  - grant register = 0.
  - rr_ptr = NUM_REQ-1, so channel 0 wins first.
- Reset mid-transaction drops the transaction silently. Any later mem_resp is ignored while in IDLE.
- State IDLE:
  - A channel is requesting when req_read[i] | req_write[i].
  - If any channel requests, the picker selects the first requesting channel scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ.
  - On the same edge, latch grant index, op (write if req_write set, else read), addr and wdata. Set rr_ptr = grant. Go to BUSY.
  - If no channel requests, stay in IDLE.
- State BUSY:
  - mem_read/mem_write are driven from the latched op; mem_addr/mem_wdata from the latched registers. All are registered outputs, first asserted the cycle after the IDLE grant.
  - Requester inputs are ignored. A request dropped mid-transaction still completes downstream and still receives req_resp.
  - On mem_resp=1 (same cycle):
    - req_resp[grant] = 1, combinational.
    - req_rdata = mem_rdata, valid for reads and for writes.
    - mem_read/mem_write deassert on the next edge.
    - Go to DONE.
- State DONE: one guard cycle with no arbitration, so the requester can drop its request. Next state is IDLE.
- req_rdata = mem_rdata when (state==BUSY && mem_resp), else 0.
- req_resp is 0 outside BUSY.
- Latency:
  - Grant edge T.
  - Downstream request visible in cycle T+1.
  - req_resp in the same cycle as mem_resp (cycle R).
  - The earliest next grant decision is made in cycle R+2.
- Simultaneous read and write on one channel is illegal. The write is issued and the read is ignored.
- All channels requesting continuously are granted in strict rotation 0,1,...,NUM_REQ-1,0,...
- A channel never waits more than NUM_REQ-1 transactions.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- Defined:
  - Adds output perf_grant_cnt (NUM_REQ*32): per-channel count of grants, incremented on the grant edge.
  - Adds output perf_wait_cnt (NUM_REQ*32): per-channel count of cycles with a pending request that is not the one in service.
  - Counters saturate at 32'hFFFF_FFFF and reset to 0 with reset_n.
- Not defined: the ports and logic are absent. Functional behaviour is identical in both builds.

Decomposition:
- Package arb_pkg holds:
  - enum arb_state_t {IDLE, BUSY, DONE}.
  - enum arb_op_t {ARB_READ, ARB_WRITE}.
  - Default constants ARB_LINE_WIDTH=256 and ARB_ADDR_WIDTH=32.
- One sub-module: rr_picker, parametrised by NUM_REQ.
  - Combinational: takes a request vector and rr_ptr; returns a valid flag and the grant index.
  - Unit-testable on its own.

Test Plan:
- Single channel read: NUM_REQ=2, ch0 read addr 32'h0000_1000. Required response:
  - mem_read=1 and mem_addr=32'h1000 one cycle after the grant.
  - mem_resp with mem_rdata=256'hA5... gives req_resp=2'b01 and req_rdata=256'hA5... in the same cycle.
- Simultaneous ch0 read and ch1 write out of reset: ch0 is served first. Then ch1 is served with mem_write=1 and mem_wdata equal to ch1's line. req_resp sequence is 2'b01 then 2'b10.
- Fairness: NUM_REQ=4, all channels request continuously, mem_resp arrives 3 cycles after each request. Grant order is 0,1,2,3,0,1; no channel is granted twice in a row.
- Request drop: ch1 deasserts req_read in cycle T+2 of BUSY. mem_read stays 1 until mem_resp, and req_resp[1] still pulses.
- Reset mid-transaction: reset_n=0 while in BUSY. mem_read=0 and req_resp=0 immediately. After release, a stray mem_resp produces no req_resp, and ch0 wins the next arbitration.
- ARB_PERF_CNT_EN build: ch1 waits 5 cycles behind ch0. perf_wait_cnt[1]=5, perf_grant_cnt[0]=1, perf_grant_cnt[1]=1.
